// File: rtl/matmul_result_drain_pkg.sv
// Shared definitions for the matmul result drain: FSM encoding, size derivation
// and packed-matrix element addressing helpers.
package matmul_result_drain_pkg;

  localparam int unsigned DIM_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DONE   = 2'd2
  } drain_state_e;

  function automatic int unsigned calc_max_dim(input int unsigned data_w,
                                               input int unsigned bus_w);
    return bus_w / data_w;
  endfunction

  function automatic int unsigned calc_addr_w(input int unsigned max_dim);
    return (max_dim * max_dim > 1) ? int'($clog2(max_dim * max_dim)) : 1;
  endfunction

  // Column-major element index of (r,c) inside the packed array output
  function automatic int unsigned elem_index(input int unsigned r,
                                             input int unsigned c,
                                             input int unsigned max_dim);
    return c * max_dim + r;
  endfunction

  function automatic int unsigned elem_offset(input int unsigned r,
                                              input int unsigned c,
                                              input int unsigned max_dim,
                                              input int unsigned bus_w);
    return elem_index(r, c, max_dim) * bus_w;
  endfunction

endpackage

// File: rtl/matmul_result_ptr.sv
// Row/column walker over the clamped N x M result window; exposes the pointer
// value for the next cycle so the owner can register its outputs from it.
module matmul_result_ptr
  import matmul_result_drain_pkg::*;
#(
  parameter int unsigned MAX_DIM = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic             adv_i,
  input  logic [DIM_W-1:0] n_dim_i,
  input  logic [DIM_W-1:0] m_dim_i,
  output logic [DIM_W-1:0] row_nxt_c,
  output logic [DIM_W-1:0] col_nxt_c,
  output logic             last_c,
  output logic             empty_c
);

  localparam logic [DIM_W-1:0] MAX_D = DIM_W'(MAX_DIM);

  logic [DIM_W-1:0] row_q, col_q, n_q, m_q;
  logic [DIM_W-1:0] n_clamp, m_clamp;

  assign n_clamp = (n_dim_i > MAX_D) ? MAX_D : n_dim_i;
  assign m_clamp = (m_dim_i > MAX_D) ? MAX_D : m_dim_i;
  assign empty_c = (n_clamp == '0) || (m_clamp == '0);
  assign last_c  = (row_q == n_q - DIM_W'(1)) && (col_q == m_q - DIM_W'(1));

  // The last beat wraps to (0,0) so the pointer never leaves the matrix
  always_comb begin
    row_nxt_c = row_q;
    col_nxt_c = col_q;
    if (load_i) begin
      row_nxt_c = '0;
      col_nxt_c = '0;
    end else if (adv_i) begin
      if (last_c) begin
        row_nxt_c = '0;
        col_nxt_c = '0;
      end else if (col_q == m_q - DIM_W'(1)) begin
        row_nxt_c = row_q + DIM_W'(1);
        col_nxt_c = '0;
      end else begin
        col_nxt_c = col_q + DIM_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      row_q <= '0;
      col_q <= '0;
      n_q   <= '0;
      m_q   <= '0;
    end else begin
      row_q <= row_nxt_c;
      col_q <= col_nxt_c;
      if (load_i) begin
        n_q <= n_clamp;
        m_q <= m_clamp;
      end
    end
  end

endmodule

// File: rtl/matmul_result_drain.sv
// Captures the systolic array's C matrix on finish and streams the valid
// N x M elements row-major over a valid/ready write port.
module matmul_result_drain
  import matmul_result_drain_pkg::*;
#(
  parameter  int unsigned DATA_WIDTH = 8,
  parameter  int unsigned BUS_WIDTH  = 16,
  localparam int unsigned MAX_DIM    = calc_max_dim(DATA_WIDTH, BUS_WIDTH),
  localparam int unsigned ADDR_W     = calc_addr_w(MAX_DIM),
  localparam int unsigned NUM_EL     = MAX_DIM * MAX_DIM
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic [NUM_EL*BUS_WIDTH-1:0] c_matrix_i,
  input  logic [NUM_EL-1:0]           flags_i,
  input  logic                        finish_mul_i,
  input  logic [DIM_W-1:0]            n_dim_i,
  input  logic [DIM_W-1:0]            m_dim_i,
  output logic                        wr_valid_o,
  input  logic                        wr_ready_i,
  output logic [ADDR_W-1:0]           wr_addr_o,
  output logic [BUS_WIDTH-1:0]        wr_data_o,
  output logic                        wr_ovf_o,
  output logic                        busy_o,
  output logic                        done_o,
  output logic [NUM_EL-1:0]           ovf_o,
  output logic                        drop_o,
  input  logic                        clr_i
);

  drain_state_e state_q, state_d;

  logic                              finish_q, fin_edge, beat;
  logic                              load, adv, last_c, empty_c;
  logic [DIM_W-1:0]                  row_nxt, col_nxt;
  logic [NUM_EL-1:0][BUS_WIDTH-1:0]  c_cap_q, mat_sel;
  logic [NUM_EL-1:0]                 f_cap_q, flag_sel;
  logic [ADDR_W-1:0]                 addr_d, cidx;
  logic [BUS_WIDTH-1:0]              data_d;
  logic                              wovf_d, drop_d;
  logic [NUM_EL-1:0]                 ovf_d;

  assign fin_edge = finish_mul_i & ~finish_q;
  assign beat     = wr_valid_o & wr_ready_i;

  matmul_result_ptr #(
    .MAX_DIM (MAX_DIM)
  ) u_ptr (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .load_i    (load),
    .adv_i     (adv),
    .n_dim_i   (n_dim_i),
    .m_dim_i   (m_dim_i),
    .row_nxt_c (row_nxt),
    .col_nxt_c (col_nxt),
    .last_c    (last_c),
    .empty_c   (empty_c)
  );

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    adv     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (fin_edge) begin
          load    = 1'b1;
          state_d = empty_c ? ST_DONE : ST_STREAM;
        end
      end
      ST_STREAM: begin
        if (beat) begin
          adv = 1'b1;
          if (last_c) state_d = ST_DONE;
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // Element for the next cycle; on the capture cycle it comes straight from the array
  always_comb begin
    mat_sel  = (state_q == ST_IDLE) ? c_matrix_i : c_cap_q;
    flag_sel = (state_q == ST_IDLE) ? flags_i    : f_cap_q;
    cidx     = ADDR_W'(elem_index(32'(row_nxt), 32'(col_nxt), MAX_DIM));
    addr_d   = '0;
    data_d   = '0;
    wovf_d   = 1'b0;
    if (state_d == ST_STREAM) begin
      addr_d = ADDR_W'(32'(row_nxt) * MAX_DIM + 32'(col_nxt));
      data_d = mat_sel[cidx];
      wovf_d = flag_sel[cidx];
    end
  end

  // Sticky status: a set in the same cycle as clr_i wins
  always_comb begin
    ovf_d = clr_i ? '0 : ovf_o;
    if (beat && wr_ovf_o) ovf_d[wr_addr_o] = 1'b1;
    drop_d = (clr_i ? 1'b0 : drop_o) | (fin_edge && (state_q != ST_IDLE));
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      finish_q   <= 1'b0;
      c_cap_q    <= '0;
      f_cap_q    <= '0;
      wr_valid_o <= 1'b0;
      wr_addr_o  <= '0;
      wr_data_o  <= '0;
      wr_ovf_o   <= 1'b0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      ovf_o      <= '0;
      drop_o     <= 1'b0;
    end else begin
      finish_q <= finish_mul_i;
      if (load) begin
        c_cap_q <= c_matrix_i;
        f_cap_q <= flags_i;
      end
      wr_valid_o <= (state_d == ST_STREAM);
      wr_addr_o  <= addr_d;
      wr_data_o  <= data_d;
      wr_ovf_o   <= wovf_d;
      busy_o     <= (state_d == ST_STREAM);
      done_o     <= (state_d == ST_DONE);
      ovf_o      <= ovf_d;
      drop_o     <= drop_d;
    end
  end

endmodule

// File: doc/matmul_result_drain.md
Name: matmul_result_drain

Overview:
- Downstream of the systolic matmul array.
- On the array's finish indication it snapshots the packed C matrix and the per-PE overflow flags.
- It then streams the valid N×M result elements, one per beat, over a valid/ready write port to the scratchpad/register-file writer.
- It frees the array immediately after capture and reports completion and sticky overflow status to control.

Parameters:
- DATA_WIDTH, 8, operand element width; used only to derive MAX_DIM.
- BUS_WIDTH, 16, result element width and write-data width.
- MAX_DIM (localparam), BUS_WIDTH/DATA_WIDTH, maximum matrix dimension.
- ADDR_W (localparam), max(1, clog2(MAX_DIM*MAX_DIM)), element address width.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset
- c_matrix_i  in  MAX_DIM*MAX_DIM*BUS_WIDTH  packed signed results; element (row r, col c) at bit offset (c*MAX_DIM+r)*BUS_WIDTH
- flags_i  in  MAX_DIM*MAX_DIM  PE overflow flags; element (r,c) at bit r+c*MAX_DIM
- finish_mul_i  in  1  array finished; level, may stay high several cycles
- n_dim_i  in  3  result rows N
- m_dim_i  in  3  result cols M
- wr_valid_o  out  1  write beat valid
- wr_ready_i  in  1  downstream accepts beat
- wr_addr_o  out  ADDR_W  element address r*MAX_DIM+c (row-major)
- wr_data_o  out  BUS_WIDTH  element value
- wr_ovf_o  out  1  overflow flag of current element
- busy_o  out  1  capture/stream in progress
- done_o  out  1  one-cycle completion pulse
- ovf_o  out  MAX_DIM*MAX_DIM  sticky overflow flags, row-major bit r*MAX_DIM+c, written elements only
- drop_o  out  1  sticky: a finish edge arrived while busy
- clr_i  in  1  synchronous clear of ovf_o and drop_o

Behaviour:
- Reset is rst_ni, asynchronous, active-low; the clock is clk_i.
- Reset values: all outputs 0; FSM in IDLE; internal finish_q = 0; capture registers = 0.
- Edge detect: fin_edge = finish_mul_i & ~finish_q; finish_q is updated every cycle.
- FSM states IDLE, STREAM, DONE.
- IDLE:
  - On fin_edge, latch c_matrix_i, flags_i, and clamped dims: dimension = min(dim, MAX_DIM).
  - Reset the row/col counters to (0,0).
  - Go to STREAM, or directly to DONE if either clamped dim is 0.
  - busy_o rises the cycle after the edge.
- STREAM:
  - wr_valid_o = 1.
  - wr_addr_o, wr_data_o and wr_ovf_o are driven from the counters and the captured data.
  - On wr_valid_o & wr_ready_i: set ovf_o bit for the element if its flag is 1, then advance col; at col = M-1 wrap col to 0 and increment row.
  - On the beat that accepts (N-1, M-1), go to DONE.
  - Without ready, valid/addr/data/ovf are held stable; valid is never withdrawn.
- DONE: done_o = 1 for exactly one cycle; busy_o = 0; next state IDLE.
- Throughput: one element per cycle with ready held high. First beat is presented 1 cycle after the capturing edge. done_o follows the last accepted beat by 1 cycle. Total for N×M with ready=1 is N*M+1 cycles from capture to done_o.
- fin_edge in STREAM or DONE: ignored, no recapture; drop_o is set. A level that stays high never retriggers.
- clr_i: clears ovf_o/drop_o. If a set occurs in the same cycle, set wins.
- Asynchronous reset mid-stream: aborts immediately. No done_o. Partial beats are not replayed.
- Arithmetic: none beyond counters. Data is passed through unchanged, signed two's complement, BUS_WIDTH bits.

Decomposition:
- Shared package holds the FSM state encoding (IDLE/STREAM/DONE), MAX_DIM/ADDR_W derivation, and an element-offset helper function (r,c → packed bit offset), reused by the matmul array bench.
- One natural sub-module: matmul_result_ptr, the row/col counter with clamp, wrap and last detection.

Test Plan:
- Configuration for all scenarios: DATA_WIDTH=8, BUS_WIDTH=16.
- Basic 2×2: N=M=2, C=[[5,-3],[7,100]], ready=1, finish pulse → beats (0,0x0005),(1,0xFFFD),(2,0x0007),(3,0x0064) on consecutive cycles, done_o 1 cycle after the last beat.
- Partial dims: N=1, M=2 → exactly 2 beats, addr 0,1; N=0 → no beats, done_o 1 cycle after capture.
- Backpressure: ready toggles 1,0,0,1,… → addr/data stable while stalled, no beat lost or duplicated, 4 beats total.
- Overflow and sticky flags: flags_i set at element (1,0) → wr_ovf_o=1 only on addr 2, ovf_o=4'b0100 after; clr_i → ovf_o=0.
- Finish level and drop: finish_mul_i held high 5 cycles → one transfer only; new edge mid-stream → drop_o=1, stream data unchanged.
- Reset mid-stream: rst_ni low after beat 1 → all outputs 0 at once, no done_o; next finish edge gives a full fresh transfer.
